// File: rtl/flag_stack_reg_if.sv
// flag_stack_reg_if
//   Bundles the flag write port, the checkpoint controls and the status
//   outputs of flag_stack_reg.
//
//   Request semantics: wr_en, push, pop and clr_err are single-cycle strobes
//   that are sampled on the rising clock edge. There is no ready signal.
//   The block accepts every request in the cycle it is presented. A request
//   it cannot honour (push when full, pop when empty) is dropped and
//   reported through the sticky err output.
//
//   master : the producer side (ALU / pipeline control). It drives the requests.
//   slave  : the flag register. It drives flags, flags_fwd and the status outputs.
interface flag_stack_reg_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             wr_en;
    logic [WIDTH-1:0] wr_mask;
    logic [WIDTH-1:0] wr_flags;
    logic             push;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] flags;
    logic [WIDTH-1:0] flags_fwd;
    logic [DW-1:0]    depth;
    logic             full;
    logic             empty;
    logic             err;

    modport master (
        output wr_en, wr_mask, wr_flags, push, pop, clr_err,
        input  flags, flags_fwd, depth, full, empty, err
    );

    modport slave (
        input  wr_en, wr_mask, wr_flags, push, pop, clr_err,
        output flags, flags_fwd, depth, full, empty, err
    );
endinterface

// File: rtl/flag_stack_reg.sv
// flag_stack_reg
//   WIDTH-bit condition-flag register with per-bit write masking, a
//   zero-latency bypass (flags_fwd), and a DEPTH-entry checkpoint stack.
//   Flags are saved and restored around speculative branches or on
//   exception entry.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : flag_stack_reg_if.slave
//            inputs  : wr_en, wr_mask, wr_flags, push, pop, clr_err
//            outputs : flags, flags_fwd, depth, full, empty, err
module flag_stack_reg #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    flag_stack_reg_if.slave   bus
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] flags_q, flags_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];

    logic [WIDTH-1:0] flags_next;
    logic [WIDTH-1:0] top_entry;
    logic [DW-1:0]    top_idx;
    logic [DW-1:0]    wr_idx;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             op_err;

    always_comb begin
        full  = (depth_q == DW'(DEPTH));
        empty = (depth_q == '0);

        flags_next = flags_q;
        if (bus.wr_en) begin
            flags_next = (flags_q & ~bus.wr_mask) | (bus.wr_flags & bus.wr_mask);
        end

        // Only meaningful when not empty. The underflow value is never used.
        top_idx   = depth_q - DW'(1);
        top_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (DW'(i) == top_idx) begin
                top_entry = stack_q[i];
            end
        end

        // A pop on a non-empty stack frees the top slot. Because of that, a
        // same-cycle push still succeeds when full (swap).
        do_pop  = bus.pop && !empty;
        do_push = bus.push && (!full || do_pop);
        op_err  = (bus.pop && empty) || (bus.push && full && !do_pop);

        // A swap overwrites the current top. A plain push writes the next free slot.
        wr_idx  = do_pop ? top_idx : depth_q;
        stack_d = stack_q;
        if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (DW'(i) == wr_idx) begin
                    stack_d[i] = flags_next;
                end
            end
        end

        // A restore from the stack takes priority over the same-cycle write.
        flags_d = do_pop ? top_entry : flags_next;

        depth_d = depth_q;
        if (do_push && !do_pop) begin
            depth_d = depth_q + DW'(1);
        end else if (do_pop && !do_push) begin
            depth_d = depth_q - DW'(1);
        end

        // A new error beats a same-cycle clear.
        err_d = err_q;
        if (op_err) begin
            err_d = 1'b1;
        end else if (bus.clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            stack_q <= stack_d;
        end
    end

    assign bus.flags     = flags_q;
    assign bus.flags_fwd = flags_next;
    assign bus.depth     = depth_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.err       = err_q;
endmodule

// File: doc/flag_stack_reg.md
Name: flag_stack_reg

Overview:
- Parametrised successor to the single 3-bit condition-flag register.
- Holds WIDTH condition flags with per-bit write masking and a same-cycle bypass output.
- Adds a DEPTH-entry checkpoint stack: flags can be saved (push) and restored (pop) around speculative branches or exception entry.
- Sits between the ALU flag outputs and the branch/condition logic of the pipelined CPU.

Parameters:
- WIDTH, 4, number of flag bits; default ordering is {Negative, Zero, Overflow, Cout}.
- DEPTH, 4, number of checkpoint entries (DEPTH >= 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- wr_en  input  1  flag write request this cycle.
- wr_mask  input  WIDTH  per-bit write enable; only bits set to 1 update.
- wr_flags  input  WIDTH  new flag values from the ALU.
- push  input  1  checkpoint the post-write flag value.
- pop  input  1  restore the flag register from the top checkpoint.
- clr_err  input  1  synchronous clear of err.
- flags  output  WIDTH  registered committed flags.
- flags_fwd  output  WIDTH  combinational bypass: flags with this cycle's masked write applied.
- depth  output  $clog2(DEPTH+1)  number of valid checkpoints.
- full  output  1  depth == DEPTH.
- empty  output  1  depth == 0.
- err  output  1  sticky misuse flag.

Behaviour:
- Reset (reset=0, asynchronous): flags=0, all stack entries=0, depth=0, empty=1, full=0, err=0. Outputs hold these values until the first rising edge after reset returns to 1.
- flags_next definition:
  - When wr_en=1: flags_next = (flags & ~wr_mask) | (wr_flags & wr_mask).
  - Otherwise: flags_next = flags.
  - flags_fwd = flags_next, combinational with zero latency.
- Plain write (no pop): flags <= flags_next on the clock edge; one-cycle latency to the flags output.
- Push alone, not full:
  - stack[depth] <= flags_next, so a same-cycle write is included in the checkpoint.
  - depth increments; flags <= flags_next.
- Push alone, full: the push is ignored, err <= 1, and the write still applies to flags.
- Pop alone, not empty:
  - flags <= stack[depth-1] and depth decrements.
  - Pop has priority over wr_en, so any same-cycle write is discarded.
- Pop alone, empty: the pop is ignored, err <= 1, and the write applies normally.
- Push and pop together, not empty (swap):
  - flags <= old top entry.
  - Top entry <= flags_next.
  - depth is unchanged; this holds even when full, and no err is raised.
- Push and pop together, empty: the pop error sets err <= 1; the push proceeds as a normal push (depth becomes 1, flags <= flags_next).
- Status outputs: full and empty are registered-equivalent, derived from the depth register with no combinational path from push/pop.
- err handling:
  - err is set by any ignored operation and held until clr_err=1.
  - If clr_err and a new error occur in the same cycle, the set wins and err stays 1.
- Masking: bits with wr_mask=0 are never modified by a write; wr_mask=0 with wr_en=1 behaves as a no-op write.
- Reset mid-operation: the asynchronous clear takes effect immediately regardless of push/pop/wr_en; no partial stack update survives.
- Stack entries above depth hold stale data and are never observable.

Test Plan:
- Reset, then wr_en=1, wr_mask=4'b1111, wr_flags=4'b1010 -> flags_fwd=1010 in the same cycle; flags=1010 after one edge; depth=0, empty=1.
- flags=1010; wr_en=1, wr_mask=4'b0011, wr_flags=4'b0101 -> flags=1001 next cycle (upper bits kept).
- flags=1001; push with wr_en=1, mask=1111, wr_flags=0000 -> flags=0000, depth=1, stack[0]=0000. Then write 1111, then pop -> flags=0000, depth=0, empty=1.
- Push 4 times (DEPTH=4) with flags 0001, 0010, 0100, 1000 -> full=1, depth=4. A 5th push -> depth=4, err=1. clr_err -> err=0. Pop four times -> flags 1000, 0100, 0010, 0001 in order.
- Depth=2 with top=0100, flags=0011; push+pop with wr_en=1, mask=1111, wr_flags=1100 -> flags=0100, top=1100, depth=2, err=0.
- Empty; pop with wr_en=1, wr_flags=0110, mask=1111 -> err=1, flags=0110, depth=0. Assert reset mid-sequence at depth=3 -> flags=0, depth=0, err=0 immediately.
